// File: rtl/line_burst_adapter_if.sv
// Client and memory-side signal bundle for line_burst_adapter.
// slave = the adapter; master = clients plus memory model.
interface line_burst_adapter_if #(
    parameter int ADDR_W    = 32,
    parameter int BEAT_W    = 64,
    parameter int NUM_BEATS = 4
);
    localparam int LINE_W = BEAT_W * NUM_BEATS;

    logic [1:0][ADDR_W-1:0] c_addr;
    logic [1:0]             c_read;
    logic [1:0]             c_write;
    logic [1:0][LINE_W-1:0] c_wdata;
    logic [1:0][LINE_W-1:0] c_rdata;
    logic [1:0]             c_resp;

    logic [ADDR_W-1:0]      bmem_addr;
    logic                   bmem_read;
    logic                   bmem_write;
    logic [BEAT_W-1:0]      bmem_wdata;
    logic                   bmem_ready;
    logic [ADDR_W-1:0]      bmem_raddr;
    logic [BEAT_W-1:0]      bmem_rdata;
    logic                   bmem_rvalid;
    logic                   err;

    modport slave (
        input  c_addr, c_read, c_write, c_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output c_rdata, c_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata, err
    );

    modport master (
        output c_addr, c_read, c_write, c_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  c_rdata, c_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata, err
    );
endinterface

// File: rtl/line_burst_adapter.sv
// Two-client cacheline adapter: round-robin issue, 4-beat write bursts,
// out-of-order read burst reassembly matched by returned line address.
// Ports: clk, rst (async active-low), bus (line_burst_adapter_if.slave).
module line_burst_adapter #(
    parameter int ADDR_W    = 32,
    parameter int BEAT_W    = 64,
    parameter int NUM_BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    line_burst_adapter_if.slave  bus
);
    localparam int LINE_W = BEAT_W * NUM_BEATS;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = $clog2(NUM_BEATS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_BUSY = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [0:0] ISSUE_IDLE = 1'b0;
    localparam logic [0:0] WBURST     = 1'b1;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BEATS - 1);

    logic [1:0][1:0]                   slot;
    logic [0:0]                        issue;
    logic                              wport;
    logic [CNT_W-1:0]                  wbeat;
    logic                              rr;
    logic [CNT_W-1:0]                  rcnt;
    logic [1:0]                        rtgt;
    logic [NUM_BEATS-1:0][BEAT_W-1:0]  rbuf;
    logic [NUM_BEATS-1:0][BEAT_W-1:0]  rnext;
    logic [NUM_BEATS-1:0][BEAT_W-1:0]  wline;

    logic [1:0] elig;
    logic [1:0] match;
    logic [1:0] tgt;
    logic       gnt_valid;
    logic       gnt_port;
    logic       gnt_rd;
    logic       take;
    logic       unused_ok;

    // Line offset bits never take part in matching or addressing.
    assign unused_ok = ^{bus.c_addr[0][OFF_W-1:0],
                         bus.c_addr[1][OFF_W-1:0],
                         bus.bmem_raddr[OFF_W-1:0]};

    // Gating with rst keeps every output low while reset is held,
    // even if a client is already requesting.
    always_comb begin
        elig  = '0;
        match = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i]  = rst && (issue == ISSUE_IDLE)
                       && (slot[i] == S_IDLE)
                       && (bus.c_read[i] || bus.c_write[i]);
            match[i] = (slot[i] == S_RD_WAIT)
                       && (bus.c_addr[i][ADDR_W-1:OFF_W]
                           == bus.bmem_raddr[ADDR_W-1:OFF_W]);
        end
    end

    assign gnt_valid = |elig;
    assign gnt_port  = elig[rr] ? rr : ~rr;
    assign gnt_rd    = bus.c_read[gnt_port];
    assign take      = gnt_valid && bus.bmem_ready;
    assign wline     = bus.c_wdata[wport];

    // Target is latched on the first beat; later beats reuse it.
    assign tgt = (rcnt == '0) ? match : rtgt;

    always_comb begin
        rnext        = rbuf;
        rnext[rcnt]  = bus.bmem_rdata;
    end

    always_comb begin
        bus.bmem_addr  = '0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_wdata = '0;
        if (issue == WBURST) begin
            bus.bmem_addr  = {bus.c_addr[wport][ADDR_W-1:OFF_W],
                              OFF_W'(0)};
            bus.bmem_write = 1'b1;
            bus.bmem_wdata = wline[wbeat];
        end else if (gnt_valid) begin
            bus.bmem_addr  = {bus.c_addr[gnt_port][ADDR_W-1:OFF_W],
                              OFF_W'(0)};
            bus.bmem_read  = gnt_rd;
            bus.bmem_write = !gnt_rd;
            bus.bmem_wdata = bus.c_wdata[gnt_port][BEAT_W-1:0];
        end
    end

    assign bus.c_resp = {slot[1] == S_RESP, slot[0] == S_RESP};

    // Issue, write-burst and return paths touch disjoint slot states,
    // so their slot updates never collide within one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot        <= '0;
            issue       <= ISSUE_IDLE;
            wport       <= 1'b0;
            wbeat       <= '0;
            rr          <= 1'b0;
            rcnt        <= '0;
            rtgt        <= '0;
            rbuf        <= '0;
            bus.c_rdata <= '0;
            bus.err     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (slot[i] == S_RESP) slot[i] <= S_IDLE;
            end

            if (take) begin
                rr <= ~gnt_port;
                if (gnt_rd) begin
                    slot[gnt_port] <= S_RD_WAIT;
                end else begin
                    slot[gnt_port] <= S_WR_BUSY;
                    issue          <= WBURST;
                    wport          <= gnt_port;
                    wbeat          <= CNT_W'(1);
                end
            end

            if (issue == WBURST && bus.bmem_ready) begin
                if (wbeat == LAST) begin
                    slot[wport] <= S_RESP;
                    issue       <= ISSUE_IDLE;
                    wbeat       <= '0;
                end else begin
                    wbeat <= wbeat + 1'b1;
                end
            end

            if (bus.bmem_rvalid) begin
                rbuf <= rnext;
                rcnt <= rcnt + 1'b1;
                if (rcnt == '0) begin
                    rtgt <= match;
                    if (match == '0) bus.err <= 1'b1;
                end
                if (rcnt == LAST) begin
                    for (int i = 0; i < 2; i++) begin
                        if (tgt[i]) begin
                            bus.c_rdata[i] <= rnext;
                            slot[i]        <= S_RESP;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed self-checking bench for line_burst_adapter.
// Inputs driven on negedge; outputs sampled 1 time unit later.
module tb_line_burst_adapter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    line_burst_adapter_if #(.ADDR_W(32), .BEAT_W(64), .NUM_BEATS(4)) bus ();

    line_burst_adapter #(.ADDR_W(32), .BEAT_W(64), .NUM_BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic return_burst(input logic [31:0] a,
                                input logic [255:0] line,
                                input bit gap);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (gap && j == 2) begin
                bus.bmem_rvalid = 1'b0;
                bus.bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                @(negedge clk);
            end
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = a;
            bus.bmem_rdata  = line[64*j +: 64];
        end
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.c_addr = '0; bus.c_read = '0; bus.c_write = '0;
        bus.c_wdata = '0; bus.bmem_ready = 1'b1;
        bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        bus.c_read[0] = 1'b1;
        bus.c_addr[0] = 32'h0000_4000;
        #1;
        checks++;
        if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0
            || bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus: rd=%b wr=%b addr=%h wdata=%h, want all 0",
                     bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata);
        end
        checks++;
        if (bus.c_resp !== 2'b00 || bus.err !== 1'b0
            || bus.c_rdata !== '0) begin
            errors++;
            $display("FAIL reset_client: resp=%b err=%b, want 00/0 and rdata 0",
                     bus.c_resp, bus.err);
        end
        @(negedge clk);
        bus.c_read[0] = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_read_single();
        logic [255:0] line;
        line = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444,
                64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        @(negedge clk);
        bus.c_addr[0] = 32'h0000_101F;
        bus.c_read[0] = 1'b1;
        #1;
        checks++;
        if (bus.bmem_read !== 1'b1 || bus.bmem_write !== 1'b0
            || bus.bmem_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL t1_cmd: rd=%b wr=%b addr=%h, want 1/0/00001000",
                     bus.bmem_read, bus.bmem_write, bus.bmem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL t1_single_cmd: rd=%b, want 0", bus.bmem_read);
        end
        return_burst(32'h0000_1008, line, 1'b1);
        checks++;
        if (bus.c_resp !== 2'b01 || bus.c_rdata[0] !== line) begin
            errors++;
            $display("FAIL t1_resp: resp=%b rdata=%h, want 01 %h",
                     bus.c_resp, bus.c_rdata[0], line);
        end
        bus.c_read[0] = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.c_resp !== 2'b00 || bus.c_rdata[0] !== line) begin
            errors++;
            $display("FAIL t1_hold: resp=%b rdata=%h, want 00 %h",
                     bus.c_resp, bus.c_rdata[0], line);
        end
    endtask

    task automatic test_write_burst();
        logic [255:0] line;
        line = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
                64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
        @(negedge clk);
        bus.c_addr[1]  = 32'h0000_2040;
        bus.c_wdata[1] = line;
        bus.c_write[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (bus.bmem_write !== 1'b1 || bus.bmem_read !== 1'b0
                || bus.bmem_addr !== 32'h0000_2040
                || bus.bmem_wdata !== line[64*k +: 64]
                || bus.c_resp !== 2'b00) begin
                errors++;
                $display("FAIL t2_beat%0d: wr=%b rd=%b addr=%h wdata=%h resp=%b, want 1/0/00002040/%h/00",
                         k, bus.bmem_write, bus.bmem_read, bus.bmem_addr,
                         bus.bmem_wdata, bus.c_resp, line[64*k +: 64]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.c_resp !== 2'b10 || bus.bmem_write !== 1'b0) begin
            errors++;
            $display("FAIL t2_resp: resp=%b wr=%b, want 10/0",
                     bus.c_resp, bus.bmem_write);
        end
        bus.c_write[1] = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.c_resp !== 2'b00) begin
            errors++;
            $display("FAIL t2_resp_pulse: resp=%b, want 00", bus.c_resp);
        end
    endtask

    task automatic test_write_stall();
        logic [255:0] line;
        int exp_beat [7];
        bit rdy [7];
        exp_beat = '{0, 1, 1, 1, 1, 2, 3};
        rdy      = '{1, 0, 0, 0, 1, 1, 1};
        line = {64'hE3E3_E3E3_0000_3333, 64'hE2E2_E2E2_0000_2222,
                64'hE1E1_E1E1_0000_1111, 64'hE0E0_E0E0_0000_0000};
        @(negedge clk);
        bus.c_addr[0]  = 32'h0000_3000;
        bus.c_wdata[0] = line;
        bus.c_write[0] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            bus.bmem_ready = rdy[c];
            #1;
            checks++;
            if (bus.bmem_write !== 1'b1 || bus.bmem_read !== 1'b0
                || bus.bmem_wdata !== line[64*exp_beat[c] +: 64]
                || bus.c_resp !== 2'b00) begin
                errors++;
                $display("FAIL t3_cyc%0d: wr=%b rd=%b wdata=%h resp=%b, want 1/0/%h/00",
                         c, bus.bmem_write, bus.bmem_read, bus.bmem_wdata,
                         bus.c_resp, line[64*exp_beat[c] +: 64]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (bus.c_resp !== 2'b01) begin
            errors++;
            $display("FAIL t3_resp: resp=%b, want 01", bus.c_resp);
        end
        bus.c_write[0] = 1'b0;
    endtask

    task automatic test_out_of_order();
        logic [255:0] l0;
        logic [255:0] l1;
        l0 = {4{64'h0000_0100_AAAA_0000}} ^ 256'h3;
        l1 = {4{64'h0000_0200_BBBB_0000}} ^ {64'h3, 64'h2, 64'h1, 64'h0};
        @(negedge clk);
        bus.c_addr[0] = 32'h0000_0100; bus.c_read[0] = 1'b1;
        bus.c_addr[1] = 32'h0000_0200; bus.c_read[1] = 1'b1;
        #1;
        checks++;
        if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL t4_grant1: rd=%b addr=%h, want 1/00000200",
                     bus.bmem_read, bus.bmem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL t4_grant0: rd=%b addr=%h, want 1/00000100",
                     bus.bmem_read, bus.bmem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.bmem_read !== 1'b0 || bus.bmem_write !== 1'b0) begin
            errors++;
            $display("FAIL t4_quiet: rd=%b wr=%b, want 0/0",
                     bus.bmem_read, bus.bmem_write);
        end
        return_burst(32'h0000_0200, l1, 1'b0);
        checks++;
        if (bus.c_resp !== 2'b10 || bus.c_rdata[1] !== l1) begin
            errors++;
            $display("FAIL t4_resp1: resp=%b rdata=%h, want 10 %h",
                     bus.c_resp, bus.c_rdata[1], l1);
        end
        bus.c_read[1] = 1'b0;
        return_burst(32'h0000_0100, l0, 1'b0);
        checks++;
        if (bus.c_resp !== 2'b01 || bus.c_rdata[0] !== l0
            || bus.c_rdata[1] !== l1) begin
            errors++;
            $display("FAIL t4_resp0: resp=%b rdata0=%h, want 01 %h",
                     bus.c_resp, bus.c_rdata[0], l0);
        end
        bus.c_read[0] = 1'b0;
    endtask

    task automatic test_rr_fairness();
        logic [31:0]  a0;
        logic [31:0]  a1;
        logic [255:0] l;
        for (int r = 0; r < 2; r++) begin
            a0 = 32'h0000_0500 + 32'(r) * 32'h40;
            a1 = 32'h0000_0600 + 32'(r) * 32'h40;
            l  = {4{64'h5A5A_0000_0000_0000 | 64'(r)}};
            @(negedge clk);
            bus.c_addr[0] = a0; bus.c_read[0] = 1'b1;
            bus.c_addr[1] = a1; bus.c_read[1] = 1'b1;
            #1;
            checks++;
            if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== a1) begin
                errors++;
                $display("FAIL t5_r%0d_first: addr=%h, want %h",
                         r, bus.bmem_addr, a1);
            end
            @(negedge clk); #1;
            checks++;
            if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== a0) begin
                errors++;
                $display("FAIL t5_r%0d_second: addr=%h, want %h",
                         r, bus.bmem_addr, a0);
            end
            return_burst(a0, l, 1'b0);
            checks++;
            if (bus.c_resp !== 2'b01 || bus.c_rdata[0] !== l) begin
                errors++;
                $display("FAIL t5_r%0d_resp0: resp=%b, want 01", r, bus.c_resp);
            end
            bus.c_read[0] = 1'b0;
            return_burst(a1, ~l, 1'b0);
            checks++;
            if (bus.c_resp !== 2'b10 || bus.c_rdata[1] !== ~l) begin
                errors++;
                $display("FAIL t5_r%0d_resp1: resp=%b, want 10", r, bus.c_resp);
            end
            bus.c_read[1] = 1'b0;
        end
    endtask

    task automatic test_same_line();
        logic [255:0] l;
        l = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
             64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
        @(negedge clk);
        bus.c_addr[0] = 32'h0000_0700; bus.c_read[0] = 1'b1;
        bus.c_addr[1] = 32'h0000_0710; bus.c_read[1] = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus.bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL same_line_cmds: rd=%b, want 0", bus.bmem_read);
        end
        return_burst(32'h0000_0700, l, 1'b0);
        checks++;
        if (bus.c_resp !== 2'b11 || bus.c_rdata[0] !== l
            || bus.c_rdata[1] !== l) begin
            errors++;
            $display("FAIL same_line_resp: resp=%b, want 11 with both lines %h",
                     bus.c_resp, l);
        end
        bus.c_read = 2'b00;
    endtask

    task automatic test_err_and_reset();
        logic [255:0] l;
        l = {4{64'h0808_0808_0808_0808}} ^ {64'h3, 64'h2, 64'h1, 64'h0};
        @(negedge clk); #1;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL t6_err_clear: err=%b, want 0", bus.err);
        end
        return_burst(32'h9999_0000, 256'h1234, 1'b0);
        checks++;
        if (bus.err !== 1'b1 || bus.c_resp !== 2'b00) begin
            errors++;
            $display("FAIL t6_err_set: err=%b resp=%b, want 1/00",
                     bus.err, bus.c_resp);
        end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL t6_err_sticky: err=%b, want 1", bus.err);
        end
        @(negedge clk);
        bus.c_addr[0] = 32'h0000_0800; bus.c_wdata[0] = l;
        bus.c_write[0] = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.bmem_write !== 1'b1 || bus.bmem_wdata !== l[127:64]) begin
            errors++;
            $display("FAIL t6_burst: wr=%b wdata=%h, want 1/%h",
                     bus.bmem_write, bus.bmem_wdata, l[127:64]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.bmem_write !== 1'b0 || bus.bmem_read !== 1'b0
            || bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== 64'h0
            || bus.c_resp !== 2'b00 || bus.err !== 1'b0
            || bus.c_rdata !== '0) begin
            errors++;
            $display("FAIL t6_async_rst: wr=%b rd=%b addr=%h wdata=%h resp=%b err=%b, want all 0",
                     bus.bmem_write, bus.bmem_read, bus.bmem_addr,
                     bus.bmem_wdata, bus.c_resp, bus.err);
        end
        @(negedge clk);
        bus.c_write[0] = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_rr_after_reset();
        @(negedge clk);
        bus.c_addr[0] = 32'h0000_0A00; bus.c_read[0] = 1'b1;
        bus.c_addr[1] = 32'h0000_0B00; bus.c_read[1] = 1'b1;
        #1;
        checks++;
        if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h0000_0A00) begin
            errors++;
            $display("FAIL rr_reset_first: rd=%b addr=%h, want 1/00000A00",
                     bus.bmem_read, bus.bmem_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.bmem_read !== 1'b1 || bus.bmem_addr !== 32'h0000_0B00) begin
            errors++;
            $display("FAIL rr_reset_second: rd=%b addr=%h, want 1/00000B00",
                     bus.bmem_read, bus.bmem_addr);
        end
        bus.c_read = 2'b00;
    endtask

    initial begin
        test_reset();
        test_read_single();
        test_write_burst();
        test_write_stall();
        test_out_of_order();
        test_rr_fairness();
        test_same_line();
        test_err_and_reset();
        test_rr_after_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
